// File: rtl/mem_req_sched.sv
// mem_req_sched: two-port round-robin scheduler for a single memory channel.
// Define MEM_REQ_SCHED_TIMEOUT_EN to bound WAIT and raise timeout_err.
module mem_req_sched #(
   parameter int unsigned ADDRESS_WIDTH  = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_1,
   input  logic                     req_2,
   input  logic                     store_1,
   input  logic                     store_2,
   input  logic                     word_1,
   input  logic                     word_2,
   input  logic [ADDRESS_WIDTH-1:0] addr_1,
   input  logic [ADDRESS_WIDTH-1:0] addr_2,
   input  logic [DATA_WIDTH-1:0]    data_1,
   input  logic [DATA_WIDTH-1:0]    data_2,
   output logic                     grant_1,
   output logic                     grant_2,
   output logic                     mem_req,
   output logic                     mem_store,
   output logic                     mem_word,
   output logic [ADDRESS_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0]    mem_data,
   input  logic                     mem_resp_valid,
   output logic                     timeout_err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t state_q, state_d;
   logic last_q, last_d;
   logic hold_q, hold_d;
   logic grant_1_q, grant_1_d;
   logic grant_2_q, grant_2_d;
   logic mem_req_q, mem_req_d;
   logic mem_store_q, mem_store_d;
   logic mem_word_q, mem_word_d;
   logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
   logic sel_2;

`ifdef MEM_REQ_SCHED_TIMEOUT_EN
   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic prev_last_q, prev_last_d;
   logic timeout_q, timeout_d;
`endif

   // last_q = 1 means port 2 won the previous selection
   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      hold_d      = hold_q;
      grant_1_d   = grant_1_q;
      grant_2_d   = grant_2_q;
      mem_req_d   = 1'b0;
      mem_store_d = mem_store_q;
      mem_word_d  = mem_word_q;
      mem_addr_d  = mem_addr_q;
      mem_data_d  = mem_data_q;
      sel_2       = req_2 && (!req_1 || !last_q);
`ifdef MEM_REQ_SCHED_TIMEOUT_EN
      cnt_d       = cnt_q;
      prev_last_d = prev_last_q;
      timeout_d   = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            hold_d = 1'b0;
            if (!hold_q && (req_1 || req_2)) begin
               state_d     = ISSUE;
               last_d      = sel_2;
               grant_1_d   = !sel_2;
               grant_2_d   = sel_2;
               mem_req_d   = 1'b1;
               mem_store_d = sel_2 ? store_2 : store_1;
               mem_word_d  = sel_2 ? word_2 : word_1;
               mem_addr_d  = sel_2 ? addr_2 : addr_1;
               mem_data_d  = sel_2 ? data_2 : data_1;
`ifdef MEM_REQ_SCHED_TIMEOUT_EN
               cnt_d       = '0;
               prev_last_d = last_q;
`endif
            end
         end
         ISSUE, WAIT: begin
            if (mem_resp_valid) begin
               state_d   = IDLE;
               grant_1_d = 1'b0;
               grant_2_d = 1'b0;
               hold_d    = 1'b1;
            end else begin
               state_d = WAIT;
`ifdef MEM_REQ_SCHED_TIMEOUT_EN
               if (state_q == WAIT) begin
                  if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                     state_d   = IDLE;
                     grant_1_d = 1'b0;
                     grant_2_d = 1'b0;
                     hold_d    = 1'b1;
                     timeout_d = 1'b1;
                     last_d    = prev_last_q;
                  end else begin
                     cnt_d = cnt_q + CW'(1);
                  end
               end
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         last_q      <= 1'b1;
         hold_q      <= 1'b0;
         grant_1_q   <= 1'b0;
         grant_2_q   <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_store_q <= 1'b0;
         mem_word_q  <= 1'b0;
         mem_addr_q  <= '0;
         mem_data_q  <= '0;
`ifdef MEM_REQ_SCHED_TIMEOUT_EN
         cnt_q       <= '0;
         prev_last_q <= 1'b1;
         timeout_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         hold_q      <= hold_d;
         grant_1_q   <= grant_1_d;
         grant_2_q   <= grant_2_d;
         mem_req_q   <= mem_req_d;
         mem_store_q <= mem_store_d;
         mem_word_q  <= mem_word_d;
         mem_addr_q  <= mem_addr_d;
         mem_data_q  <= mem_data_d;
`ifdef MEM_REQ_SCHED_TIMEOUT_EN
         cnt_q       <= cnt_d;
         prev_last_q <= prev_last_d;
         timeout_q   <= timeout_d;
`endif
      end
   end

   assign grant_1   = grant_1_q;
   assign grant_2   = grant_2_q;
   assign mem_req   = mem_req_q;
   assign mem_store = mem_store_q;
   assign mem_word  = mem_word_q;
   assign mem_addr  = mem_addr_q;
   assign mem_data  = mem_data_q;

`ifdef MEM_REQ_SCHED_TIMEOUT_EN
   assign timeout_err = timeout_q;
`else
   assign timeout_err = (TIMEOUT_CYCLES == 0) && 1'b0;
`endif

endmodule

// File: tb/tb_mem_req_sched.sv
// Scoreboard bench for mem_req_sched: directed scenarios then random traffic
// against a transaction-level reference model.
`timescale 1ns/1ps
module tb_mem_req_sched;

   localparam int AW = 32;
   localparam int DW = 32;
`ifdef MEM_REQ_SCHED_TIMEOUT_EN
   localparam int TO = 4;
`else
   localparam int TO = 64;
`endif

   logic clk = 1'b0;
   logic rst;
   logic req_1, req_2, store_1, store_2, word_1, word_2;
   logic [AW-1:0] addr_1, addr_2;
   logic [DW-1:0] data_1, data_2;
   logic grant_1, grant_2, mem_req, mem_store, mem_word;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_data;
   logic mem_resp_valid, timeout_err;

   always #5 clk = ~clk;

   mem_req_sched #(
      .ADDRESS_WIDTH(AW),
      .DATA_WIDTH(DW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst(rst),
      .req_1(req_1), .req_2(req_2),
      .store_1(store_1), .store_2(store_2),
      .word_1(word_1), .word_2(word_2),
      .addr_1(addr_1), .addr_2(addr_2),
      .data_1(data_1), .data_2(data_2),
      .grant_1(grant_1), .grant_2(grant_2),
      .mem_req(mem_req), .mem_store(mem_store), .mem_word(mem_word),
      .mem_addr(mem_addr), .mem_data(mem_data),
      .mem_resp_valid(mem_resp_valid),
      .timeout_err(timeout_err)
   );

   typedef struct packed {
      logic g1, g2, req, st, wd, terr;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } obs_t;

   typedef struct {
      bit r, q1, q2, s1, s2, w1, w2, resp;
      logic [AW-1:0] a1, a2;
      logic [DW-1:0] d1, d2;
   } in_t;

   obs_t exp_q[$];
   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   // Reference model: owner of the channel and what was latched for it
   bit m_busy, m_first, m_hold, m_own2, m_last2, m_prev2;
   int m_waits;
   logic m_st, m_wd;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data;

   function automatic in_t quiet();
      in_t v;
      v = '{default: 0};
      return v;
   endfunction

   task automatic step(input in_t v);
      obs_t e;
      bit fresh, terr, w2;
      @(negedge clk);
      rst = v.r; req_1 = v.q1; req_2 = v.q2;
      store_1 = v.s1; store_2 = v.s2; word_1 = v.w1; word_2 = v.w2;
      addr_1 = v.a1; addr_2 = v.a2; data_1 = v.d1; data_2 = v.d2;
      mem_resp_valid = v.resp;
      fresh = 0;
      terr = 0;
      if (v.r) begin
         m_busy = 0; m_first = 0; m_hold = 0; m_last2 = 1; m_prev2 = 1;
         m_st = 0; m_wd = 0; m_addr = '0; m_data = '0; m_waits = 0;
      end else if (!m_busy) begin
         if (!m_hold && (v.q1 || v.q2)) begin
            w2 = (v.q1 && v.q2) ? !m_last2 : v.q2;
            m_prev2 = m_last2;
            m_last2 = w2;
            m_own2 = w2;
            m_busy = 1;
            m_first = 1;
            m_waits = 0;
            fresh = 1;
            m_st = w2 ? v.s2 : v.s1;
            m_wd = w2 ? v.w2 : v.w1;
            m_addr = w2 ? v.a2 : v.a1;
            m_data = w2 ? v.d2 : v.d1;
         end
         m_hold = 0;
      end else begin
         if (v.resp) begin
            m_busy = 0;
            m_hold = 1;
         end else if (!m_first) begin
            m_waits++;
`ifdef MEM_REQ_SCHED_TIMEOUT_EN
            if (m_waits == TO) begin
               m_busy = 0;
               m_hold = 1;
               terr = 1;
               m_last2 = m_prev2;
            end
`endif
         end
         m_first = 0;
      end
      e.g1 = m_busy && !m_own2;
      e.g2 = m_busy && m_own2;
      e.req = fresh;
      e.st = m_st;
      e.wd = m_wd;
      e.terr = terr;
      e.addr = m_addr;
      e.data = m_data;
      exp_q.push_back(e);
   endtask

   task automatic do_reset();
      in_t v;
      v = quiet();
      v.r = 1;
      step(v);
      step(v);
   endtask

   initial begin : monitor
      obs_t e, a;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {grant_1, grant_2, mem_req, mem_store, mem_word,
                 timeout_err, mem_addr, mem_data};
            vectors++;
            if (a !== e) begin
               miscompares++;
               $display("FAIL outputs cyc %0d: got g1=%b g2=%b req=%b st=%b wd=%b terr=%b addr=%h data=%h, need g1=%b g2=%b req=%b st=%b wd=%b terr=%b addr=%h data=%h",
                        cyc, a.g1, a.g2, a.req, a.st, a.wd, a.terr, a.addr, a.data,
                        e.g1, e.g2, e.req, e.st, e.wd, e.terr, e.addr, e.data);
            end
         end
      end
   end

   initial begin : driver
      in_t v;
      rst = 1; req_1 = 0; req_2 = 0; store_1 = 0; store_2 = 0;
      word_1 = 0; word_2 = 0; addr_1 = '0; addr_2 = '0;
      data_1 = '0; data_2 = '0; mem_resp_valid = 0;

      // single fill request, response four cycles later
      do_reset();
      v = quiet(); v.q1 = 1; v.a1 = 'h100; v.d1 = 'h55;
      step(v);
      v = quiet();
      for (int i = 1; i <= 6; i++) begin
         v.resp = (i == 4);
         step(v);
      end

      // tie after reset, both held: 1, 2, 1
      do_reset();
      for (int i = 0; i < 20; i++) begin
         v = quiet(); v.q1 = 1; v.q2 = 1;
         v.a1 = 'h1000 + i; v.a2 = 'h2000 + i;
         v.resp = (i % 4 == 3);
         step(v);
      end

      // store from port 2, address changes while waiting
      v = quiet(); v.q2 = 1; v.s2 = 1; v.d2 = 'hAB; v.a2 = 'h203;
      step(v);
      for (int i = 0; i < 5; i++) begin
         v.a2 = '0; v.d2 = 'h11; v.s2 = 0; v.w2 = 1;
         v.resp = (i == 4);
         step(v);
      end

      // response in the ISSUE cycle, then back-to-back request
      v = quiet(); v.q1 = 1; v.w1 = 1; v.a1 = 'h40;
      step(v);
      v.resp = 1;
      step(v);
      v.resp = 0; v.a1 = 'h44;
      for (int i = 0; i < 4; i++) step(v);
      v = quiet(); v.resp = 1;
      step(v);
      v = quiet();
      step(v);

      // reset while waiting, late response in IDLE
      v = quiet(); v.q1 = 1; v.a1 = 'h300;
      step(v);
      v = quiet();
      step(v);
      step(v);
      v.r = 1;
      step(v);
      v = quiet(); v.resp = 1;
      step(v);
      step(v);
      v = quiet();
      step(v);

`ifdef MEM_REQ_SCHED_TIMEOUT_EN
      // no response: timeout, then the tie goes to the same port again
      do_reset();
      v = quiet(); v.q1 = 1; v.q2 = 1;
      for (int i = 0; i < 10; i++) step(v);
      v.resp = 1;
      step(v);
      step(v);
      v.resp = 0;
      for (int i = 0; i < 4; i++) step(v);
`endif

      for (int i = 0; i < 3000; i++) begin
         v.r = ($urandom_range(99) == 0);
         v.q1 = ($urandom_range(1) == 1);
         v.q2 = ($urandom_range(1) == 1);
         v.s1 = $urandom_range(1); v.s2 = $urandom_range(1);
         v.w1 = $urandom_range(1); v.w2 = $urandom_range(1);
         v.a1 = $urandom; v.a2 = $urandom;
         v.d1 = $urandom; v.d2 = $urandom;
`ifdef MEM_REQ_SCHED_TIMEOUT_EN
         v.resp = ($urandom_range(99) < 12);
`else
         v.resp = ($urandom_range(99) < 30);
`endif
         step(v);
      end

      @(negedge clk);
      @(negedge clk);
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expected cycles left, need 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
